// File: rtl/apd_pkg.sv
// Shared constants, types and configuration helpers for the APD event arbiter.
package apd_pkg;

  localparam int APD_NUM_CH   = 4;
  localparam int APD_TS_WIDTH = 32;
  localparam int APD_CH_WIDTH = 3;

  // Channel code carried by a timestamp wrap marker; one past the last channel.
  localparam int WRAP_CODE = APD_NUM_CH;

  // Output register state: nothing presented, or an event held until accepted.
  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } out_state_e;

  // The channel field must have a spare code above the last channel for the wrap marker.
  function automatic bit ch_width_ok(input int num_ch, input int ch_width);
    return (num_ch >= 2) && (num_ch <= 8) && ((1 << ch_width) > num_ch);
  endfunction

endpackage

// File: rtl/apd_event_arbiter_if.sv
// Valid/ready event stream from the arbiter to the event logger.
interface apd_event_arbiter_if #(
  parameter int CH_WIDTH = 3,
  parameter int TS_WIDTH = 32
);

  logic                event_valid;
  logic                event_ready;
  logic [CH_WIDTH-1:0] event_channel;
  logic [TS_WIDTH-1:0] event_timestamp;

  modport master (
    output event_valid,
    output event_channel,
    output event_timestamp,
    input  event_ready
  );

  modport slave (
    input  event_valid,
    input  event_channel,
    input  event_timestamp,
    output event_ready
  );

endinterface

// File: rtl/apd_rr_select.sv
// Combinational round-robin picker: first request found scanning upward from rr_ptr+1.
module apd_rr_select #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  rr_ptr,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              any_req
);

  logic             found_s;
  logic [IDX_W-1:0] pos_s;

  assign any_req = |req;

  // Walk the ring starting just after the last winner; the earliest requester in that order wins.
  always_comb begin
    grant_idx = '0;
    found_s   = 1'b0;
    pos_s     = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      pos_s     = IDX_W'((int'(rr_ptr) + k) % NUM_CH);
      grant_idx = (!found_s && req[pos_s]) ? pos_s : grant_idx;
      found_s   = found_s | req[pos_s];
    end
  end

endmodule

// File: rtl/apd_event_arbiter.sv
// Timestamps APD one-shot pulses, holds one pending event per channel and
// serializes them (plus timestamp wrap markers) onto a valid/ready stream.
module apd_event_arbiter
  import apd_pkg::*;
#(
  parameter int NUM_CH   = APD_NUM_CH,
  parameter int TS_WIDTH = APD_TS_WIDTH,
  parameter int CH_WIDTH = APD_CH_WIDTH
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [NUM_CH-1:0]   pulse_in,
  input  logic                clear_drops,
  output logic [NUM_CH-1:0]   drop_flags,
  output logic                wrap_overflow,
  apd_event_arbiter_if.master evt
);

  localparam int                  IDX_W   = $clog2(NUM_CH);
  localparam logic [CH_WIDTH-1:0] WRAP_CH = CH_WIDTH'(NUM_CH);
  localparam logic [IDX_W-1:0]    RR_INIT = IDX_W'(NUM_CH - 1);
  localparam logic [TS_WIDTH-1:0] TS_ONE  = {{(TS_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [TS_WIDTH-1:0] TS_MAX  = {TS_WIDTH{1'b1}};
  localparam logic [NUM_CH-1:0]   CH_ONE  = {{(NUM_CH-1){1'b0}}, 1'b1};

  if (!ch_width_ok(NUM_CH, CH_WIDTH)) begin : g_cfg_error
    $error("apd_event_arbiter: CH_WIDTH too small for NUM_CH plus wrap code, or NUM_CH out of 2..8");
  end

  // Timestamp and wrap tracking
  logic [TS_WIDTH-1:0] ts_r;
  logic                ts_wrap_s;
  logic                wrap_pending_r;
  logic                wrap_pending_n_s;
  logic                wrap_lost_s;
  logic                wrap_overflow_r;

  // Per-channel pending slots
  logic [NUM_CH-1:0]   pending_r;
  logic [TS_WIDTH-1:0] ts_hold_r [NUM_CH];
  logic [NUM_CH-1:0]   pulse_en_s;
  logic [NUM_CH-1:0]   cap_vec_s;
  logic [NUM_CH-1:0]   drop_vec_s;
  logic [NUM_CH-1:0]   drop_flags_r;

  // Arbitration
  logic [IDX_W-1:0]    rr_r;
  logic [IDX_W-1:0]    grant_idx_s;
  logic                any_req_s;
  logic                adv_s;
  logic                wrap_grant_s;
  logic                ch_grant_s;
  logic                grant_any_s;
  logic [NUM_CH-1:0]   granted_vec_s;

  // Output register
  out_state_e          state_r;
  out_state_e          state_n;
  logic                valid_r;
  logic [CH_WIDTH-1:0] out_ch_r;
  logic [CH_WIDTH-1:0] out_ch_n;
  logic [TS_WIDTH-1:0] out_ts_r;
  logic [TS_WIDTH-1:0] out_ts_n;

  apd_rr_select #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_rr_select (
    .req       (pending_r),
    .rr_ptr    (rr_r),
    .grant_idx (grant_idx_s),
    .any_req   (any_req_s)
  );

  // The output slot can take a new event when empty or when its current event is being accepted.
  assign adv_s         = (state_r == ST_IDLE) | evt.event_ready;
  assign wrap_grant_s  = adv_s & wrap_pending_r;
  assign ch_grant_s    = adv_s & ~wrap_pending_r & any_req_s;
  assign grant_any_s   = wrap_grant_s | ch_grant_s;
  assign granted_vec_s = ch_grant_s ? (CH_ONE << grant_idx_s) : '0;

  // A pulse finds room if its slot is empty or the slot is being emptied by a grant this cycle.
  assign pulse_en_s = pulse_in & {NUM_CH{enable}};
  assign cap_vec_s  = pulse_en_s & (~pending_r | granted_vec_s);
  assign drop_vec_s = pulse_en_s & pending_r & ~granted_vec_s;

  // A wrap marker being granted frees its flag, so a coincident new wrap is not lost.
  assign ts_wrap_s        = enable & (ts_r == TS_MAX);
  assign wrap_pending_n_s = ts_wrap_s | (wrap_pending_r & ~wrap_grant_s);
  assign wrap_lost_s      = ts_wrap_s & wrap_pending_r & ~wrap_grant_s;

  // Free-running timestamp, forced to zero while acquisition is disabled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ts_r           <= '0;
      wrap_pending_r <= 1'b0;
    end else begin
      ts_r           <= enable ? (ts_r + TS_ONE) : '0;
      wrap_pending_r <= wrap_pending_n_s;
    end
  end

  // Pending slots: capture wins over the clear of a slot granted in the same cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_r <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        ts_hold_r[i] <= '0;
      end
    end else begin
      pending_r <= cap_vec_s | (pending_r & ~granted_vec_s);
      for (int i = 0; i < NUM_CH; i++) begin
        if (cap_vec_s[i]) begin
          ts_hold_r[i] <= ts_r;
        end
      end
    end
  end

  // Sticky loss flags; a new loss in the clearing cycle still sets the flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      drop_flags_r    <= '0;
      wrap_overflow_r <= 1'b0;
    end else begin
      drop_flags_r    <= (drop_flags_r & ~{NUM_CH{clear_drops}}) | drop_vec_s;
      wrap_overflow_r <= (wrap_overflow_r & ~clear_drops) | wrap_lost_s;
    end
  end

  // Round-robin pointer follows channel winners only; wrap grants leave it alone.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_r <= RR_INIT;
    end else if (ch_grant_s) begin
      rr_r <= grant_idx_s;
    end
  end

  // Output state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next state: load on any grant, fall idle on an accept with nothing to follow.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE: begin
        state_n = grant_any_s ? ST_PRESENT : ST_IDLE;
      end
      ST_PRESENT: begin
        if (evt.event_ready) begin
          state_n = grant_any_s ? ST_PRESENT : ST_IDLE;
        end else begin
          state_n = ST_PRESENT;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Output payload: wrap marker, granted channel's held timestamp, or hold the current event.
  always_comb begin
    out_ch_n = out_ch_r;
    out_ts_n = out_ts_r;
    if (wrap_grant_s) begin
      out_ch_n = WRAP_CH;
      out_ts_n = '0;
    end else if (ch_grant_s) begin
      out_ch_n = CH_WIDTH'(grant_idx_s);
      out_ts_n = ts_hold_r[grant_idx_s];
    end else begin
      out_ch_n = out_ch_r;
      out_ts_n = out_ts_r;
    end
  end

  // Registered stream outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_r  <= 1'b0;
      out_ch_r <= '0;
      out_ts_r <= '0;
    end else begin
      valid_r  <= (state_n == ST_PRESENT);
      out_ch_r <= out_ch_n;
      out_ts_r <= out_ts_n;
    end
  end

  assign evt.event_valid     = valid_r;
  assign evt.event_channel   = out_ch_r;
  assign evt.event_timestamp = out_ts_r;
  assign drop_flags          = drop_flags_r;
  assign wrap_overflow       = wrap_overflow_r;

endmodule

// File: tb/tb_apd_event_arbiter.sv
// Self-checking bench for apd_event_arbiter: directed scenarios plus random
// traffic, all compared cycle by cycle against a behavioural reference model.
module tb_apd_event_arbiter;
  import apd_pkg::*;

  localparam int NCH    = 4;
  localparam int TSW    = 8;
  localparam int CHW    = 3;
  localparam int TS_MOD = 256;

  logic           clock       = 1'b0;
  logic           reset_n     = 1'b0;
  logic           enable      = 1'b0;
  logic [NCH-1:0] pulse_in    = '0;
  logic           clear_drops = 1'b0;
  logic [NCH-1:0] drop_flags;
  logic           wrap_overflow;

  apd_event_arbiter_if #(.CH_WIDTH(CHW), .TS_WIDTH(TSW)) evt ();

  apd_event_arbiter #(
    .NUM_CH   (NCH),
    .TS_WIDTH (TSW),
    .CH_WIDTH (CHW)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .enable        (enable),
    .pulse_in      (pulse_in),
    .clear_drops   (clear_drops),
    .drop_flags    (drop_flags),
    .wrap_overflow (wrap_overflow),
    .evt           (evt)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: one-deep slot per channel, one presented event, wrap flag.
  bit             m_valid;
  int             m_ch;
  int             m_ots;
  bit             m_pend [NCH];
  int             m_pts  [NCH];
  int             m_rr;
  bit             m_wrap;
  bit             m_wovf;
  logic [NCH-1:0] m_drops;
  int             m_ts;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_ch = 0; m_ots = 0; m_rr = NCH - 1;
    m_wrap = 1'b0; m_wovf = 1'b0; m_drops = '0; m_ts = 0;
    for (int i = 0; i < NCH; i++) begin
      m_pend[i] = 1'b0;
      m_pts[i]  = 0;
    end
  endtask

  // One clock of the spec's rules: pick a winner, pop it, then push new pulses into free slots.
  task automatic model_step();
    bit             en, rdy, clr, can_load, wg;
    logic [NCH-1:0] p;
    int             g, c;
    en = enable; rdy = evt.event_ready; clr = clear_drops; p = pulse_in;
    can_load = !m_valid || rdy;
    g  = -1;
    wg = 1'b0;
    if (can_load && m_wrap) wg = 1'b1;
    else if (can_load) begin
      for (int k = 1; k <= NCH; k++) begin
        c = (m_rr + k) % NCH;
        if (g < 0 && m_pend[c]) g = c;
      end
    end
    if (wg) begin
      m_valid = 1'b1; m_ch = WRAP_CODE; m_ots = 0; m_wrap = 1'b0;
    end else if (g >= 0) begin
      m_valid = 1'b1; m_ch = g; m_ots = m_pts[g]; m_pend[g] = 1'b0; m_rr = g;
    end else if (can_load) begin
      m_valid = 1'b0;
    end
    if (clr) begin
      m_drops = '0;
      m_wovf  = 1'b0;
    end
    if (en) begin
      for (int i = 0; i < NCH; i++) begin
        if (p[i]) begin
          if (!m_pend[i]) begin
            m_pend[i] = 1'b1;
            m_pts[i]  = m_ts;
          end else begin
            m_drops[i] = 1'b1;
          end
        end
      end
      if (m_ts == TS_MOD - 1) begin
        if (m_wrap) m_wovf = 1'b1;
        else        m_wrap = 1'b1;
      end
    end
    m_ts = en ? (m_ts + 1) % TS_MOD : 0;
  endtask

  task automatic cmp_model();
    chk("valid", evt.event_valid, 32'(m_valid));
    chk("channel", evt.event_channel, 32'(m_ch));
    chk("timestamp", evt.event_timestamp, 32'(m_ots));
    chk("drop_flags", drop_flags, 32'(m_drops));
    chk("wrap_overflow", wrap_overflow, 32'(m_wovf));
  endtask

  task automatic step();
    @(posedge clock);
    model_step();
    #1;
    cmp_model();
    pulse_in    = '0;
    clear_drops = 1'b0;
  endtask

  // Advance until the upcoming cycle carries timestamp t (enable must be high).
  task automatic run_until_ts(input int t);
    for (int n = 0; n < 2 * TS_MOD && m_ts != t; n++) step();
    chk("ts_reached", 32'(m_ts), 32'(t));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    evt.event_ready = 1'b1;
    model_reset();

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_valid", evt.event_valid, 32'd0);
    chk("rst_channel", evt.event_channel, 32'd0);
    chk("rst_timestamp", evt.event_timestamp, 32'd0);
    chk("rst_drops", drop_flags, 32'd0);
    chk("rst_wovf", wrap_overflow, 32'd0);
    reset_n = 1'b1;

    // Enable low: pulses ignored, no drops, ts held at 0
    enable = 1'b0;
    for (int n = 0; n < 4; n++) begin
      pulse_in = 4'hF;
      step();
    end
    chk("dis_valid", evt.event_valid, 32'd0);
    chk("dis_drops", drop_flags, 32'd0);
    enable   = 1'b1;
    pulse_in = 4'b1000;
    step();
    step();
    chk("ts0_valid", evt.event_valid, 32'd1);
    chk("ts0_channel", evt.event_channel, 32'd3);
    chk("ts0_timestamp", evt.event_timestamp, 32'd0);

    // Simultaneous pulses at ts=50 and ts=60
    for (int rep = 0; rep < 2; rep++) begin
      run_until_ts(rep == 0 ? 50 : 60);
      pulse_in = 4'hF;
      step();
      step();
      for (int k = 0; k < NCH; k++) begin
        chk("sim_channel", evt.event_channel, 32'(k));
        chk("sim_timestamp", evt.event_timestamp, (rep == 0) ? 32'd50 : 32'd60);
        step();
      end
      chk("sim_idle", evt.event_valid, 32'd0);
    end

    // Single event at ts=100, two-cycle latency, one cycle wide
    run_until_ts(100);
    pulse_in = 4'b0001;
    step();
    chk("lat_c1_valid", evt.event_valid, 32'd0);
    step();
    chk("lat_c2_valid", evt.event_valid, 32'd1);
    chk("lat_channel", evt.event_channel, 32'd0);
    chk("lat_timestamp", evt.event_timestamp, 32'd100);
    step();
    chk("lat_c3_valid", evt.event_valid, 32'd0);
    chk("lat_drops", drop_flags, 32'd0);

    // Backpressure and drop
    run_until_ts(5);
    evt.event_ready = 1'b0;
    run_until_ts(10); pulse_in = 4'b0100; step();
    run_until_ts(15); pulse_in = 4'b0010; step();
    run_until_ts(20); pulse_in = 4'b0100; step();
    chk("bp_nodrop", drop_flags, 32'd0);
    run_until_ts(25); pulse_in = 4'b0100; step();
    chk("bp_drop", drop_flags, 32'b0100);
    chk("bp_hold_channel", evt.event_channel, 32'd2);
    chk("bp_hold_timestamp", evt.event_timestamp, 32'd10);
    evt.event_ready = 1'b1;
    step();
    chk("bp_ev2_channel", evt.event_channel, 32'd1);
    chk("bp_ev2_timestamp", evt.event_timestamp, 32'd15);
    step();
    chk("bp_ev3_channel", evt.event_channel, 32'd2);
    chk("bp_ev3_timestamp", evt.event_timestamp, 32'd20);
    step();
    chk("bp_idle", evt.event_valid, 32'd0);
    clear_drops = 1'b1;
    step();
    chk("bp_cleared", drop_flags, 32'd0);

    // Wrap marker ahead of a pending ch0 event, then a lost second marker
    run_until_ts(250);
    pulse_in        = 4'b0010;
    evt.event_ready = 1'b0;
    step();
    run_until_ts(252);
    pulse_in = 4'b0001;
    step();
    for (int n = 0; n < 300; n++) step();
    chk("wrap_ovf_set", wrap_overflow, 32'd1);
    chk("wrap_hold_channel", evt.event_channel, 32'd1);
    chk("wrap_hold_timestamp", evt.event_timestamp, 32'd250);
    evt.event_ready = 1'b1;
    step();
    chk("wrap_mk_channel", evt.event_channel, 32'(WRAP_CODE));
    chk("wrap_mk_timestamp", evt.event_timestamp, 32'd0);
    step();
    chk("wrap_ch0_channel", evt.event_channel, 32'd0);
    chk("wrap_ch0_timestamp", evt.event_timestamp, 32'd252);
    step();
    chk("wrap_idle", evt.event_valid, 32'd0);
    clear_drops = 1'b1;
    step();
    chk("wrap_ovf_clear", wrap_overflow, 32'd0);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      enable          = ($urandom_range(0, 9) != 0);
      evt.event_ready = ($urandom_range(0, 3) != 0);
      clear_drops     = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < NCH; i++) pulse_in[i] = ($urandom_range(0, 3) == 0);
      step();
    end

    // Reset mid-stream
    enable          = 1'b1;
    evt.event_ready = 1'b0;
    pulse_in        = 4'hF;
    step();
    step();
    chk("mid_valid_before", evt.event_valid, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_async_valid", evt.event_valid, 32'd0);
    chk("mid_async_drops", drop_flags, 32'd0);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset_n         = 1'b1;
    evt.event_ready = 1'b1;
    step();
    chk("mid_no_stale", evt.event_valid, 32'd0);
    pulse_in = 4'b1001;
    step();
    step();
    chk("mid_first_channel", evt.event_channel, 32'd0);
    chk("mid_first_timestamp", evt.event_timestamp, 32'd1);
    for (int n = 0; n < 4; n++) step();
    chk("mid_drained", evt.event_valid, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
